pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the stall/flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers and the EX-stage forwarding muxes. It also sequences the multi-cycle `multu` unit that writes HI/LO. Control transfers (branch, jump, jr) resolve in MEM, so it squashes younger instructions and aborts a multiply that a redirect has invalidated.

## Interface
Parameters:
- `MULT_CYCLES`, default 4: multiply latency in cycles; legal values are ≥ 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `rs_d`, `rt_d`: input, 5 bits each. Source registers of the instruction in ID.
- `rs_e`, `rt_e`: input, 5 bits each. Source registers of the instruction in EX.
- `rf_wa_e`, `rf_wa_m`, `rf_wa_w`: input, 5 bits each. Destination register in EX, MEM and WB.
- `we_reg_e`, `we_reg_m`, `we_reg_w`: input, 1 bit each. Register-write enables for EX, MEM and WB.
- `dm2reg_e`: input, 1 bit. The instruction in EX is a load.
- `multu_en_d`: input, 1 bit. The instruction in ID is `multu`.
- `hilo_rd_d`: input, 1 bit. The instruction in ID is `mfhi` or `mflo`.
- `branch_m`, `zero_m`, `jump_m`, `jr_sel_m`: input, 1 bit each. Control-transfer signals in MEM.
- `stall_f`, `stall_d`: output, 1 bit each. Hold the PC and the IF/ID register.
- `flush_d`, `flush_e`, `flush_m`: output, 1 bit each. Clear IF/ID, ID/EX and EX/MEM to a bubble.
- `fwd_a_e`, `fwd_b_e`: output, 2 bits each. Forwarding select for ALU operands A and B.
- `mult_start`: output, 1 bit. One-cycle pulse that launches the multiplier.
- `mult_busy`: output, 1 bit. High while the multiplier is occupied.
- `mult_done`: output, 1 bit. One-cycle pulse: write HI/LO at the end of this cycle.
- `mult_abort`: output, 1 bit. One-cycle pulse: discard the in-flight multiply.

## Operation
- **Redirect:** `redir = (branch_m & zero_m) | jump_m | jr_sel_m`.
  - When asserted: `flush_d = flush_e = flush_m = 1`, `stall_f = stall_d = 0`.
  - Redirect has priority over every stall.
- **Forwarding for operand A** (B is identical, using `rt_e`):
  - `10` (MEM) if `we_reg_m`, `rf_wa_m != 0` and `rf_wa_m == rs_e`.
  - Otherwise `01` (WB) if `we_reg_w`, `rf_wa_w != 0` and `rf_wa_w == rs_e`.
  - Otherwise `00` (register file).
  - MEM wins over WB.
- **Load-use hazard:** `dm2reg_e & we_reg_e & rf_wa_e != 0 & (rf_wa_e == rs_d | rf_wa_e == rt_d)`.
  - Response: `stall_f = stall_d = flush_e = 1`.
- **HI/LO hazard:** `mult_busy & (multu_en_d | hilo_rd_d)`.
  - Response: `stall_f = stall_d = flush_e = 1`.
- **Multiplier FSM, IDLE → BUSY:**
  - `mult_start = IDLE & multu_en_d & ~redir & ~load_use`.
  - On `mult_start`, load `cnt = MULT_CYCLES - 1` and go to BUSY.
- **BUSY behaviour:**
  - `mult_busy = 1`.
  - `cnt` decrements each cycle.
  - `mult_done = BUSY & cnt == 0`, after which the FSM returns to IDLE.
- **Abort:** in the first BUSY cycle (`cnt == MULT_CYCLES - 1`), the `multu` sits in EX.
  - If `redir` is high that cycle, the `multu` is younger than the transfer and must be squashed.
  - Response: `mult_abort = 1`, return to IDLE, no `mult_done`.
  - A `redir` in any later BUSY cycle does not abort, because the transfer is younger than the `multu`.
- **Reset:** asynchronous; it aborts any in-flight multiply silently (no `mult_abort` pulse).

## Timing
- Reset values:
  - State IDLE, `cnt = 0`.
  - Every output is 0: `fwd_*` = `00`, all stalls, flushes and `mult_*` pulses deasserted.
- All outputs are combinational from the current inputs plus registered state.
- Zero-cycle latency from hazard inputs to stall/flush outputs.
- Multiply launched in cycle t:
  - `mult_busy` is high in cycles t+1 … t+`MULT_CYCLES`.
  - `mult_done` is high in cycle t+`MULT_CYCLES`.
  - A waiting `mfhi`/`multu` is released in cycle t+`MULT_CYCLES`+1.
- A new `multu` arriving in ID during the `mult_done` cycle stalls that cycle and starts in the next cycle.
- A load-use stall lasts exactly one cycle.

## Structure
- Shared package `hazard_pkg` holds:
  - the forwarding encodings `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`;
  - the multiplier state encoding, `MS_IDLE` and `MS_BUSY`.
- One sub-module, `hilo_mult_seq`, holds the FSM, the counter and the start/done/abort logic.
- The top level holds forwarding, hazard detection and redirect priority.

## Test plan
- **Reset mid-multiply:** with `MULT_CYCLES = 4`, start a multiply and drop `rst_n` in cycle t+2 → `mult_busy`, `mult_done` and `mult_abort` are all 0 immediately; after release, `multu_en_d` starts a new multiply normally.
- **Forwarding priority:** `we_reg_m = we_reg_w = 1`, `rf_wa_m = rf_wa_w = rs_e = 5` → `fwd_a_e = 10`. With `rf_wa_m = rf_wa_w = rs_e = 0` → `fwd_a_e = 00`.
- **Load-use:** `dm2reg_e = 1`, `we_reg_e = 1`, `rf_wa_e = 8`, `rt_d = 8` → `stall_f = stall_d = flush_e = 1` for exactly one cycle; `mult_start` is suppressed if `multu_en_d` is also high.
- **Multiply sequence:** `MULT_CYCLES = 4`, `multu_en_d` in cycle 0 → `mult_start` in cycle 0, `mult_busy` in cycles 1–4, `mult_done` in cycle 4. An `mfhi` held in ID from cycle 2 stalls in cycles 2–4 and proceeds in cycle 5.
- **Abort versus no abort:** `redir` in cycle 1 → `mult_abort` in cycle 1, `mult_busy = 0` in cycle 2, no `mult_done`. `redir` in cycle 2 → no abort, and `mult_done` still fires in cycle 4.
- **Redirect plus load-use:** `jump_m = 1` in the same cycle as a load-use condition → `flush_d = flush_e = flush_m = 1`, `stall_f = stall_d = 0`.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and its multiplier sequencer.
package hazard_pkg;

   // EX-stage operand forwarding selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Multiplier sequencer states
   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_BUSY = 1'b1
   } mult_state_t;

   // Forwarding select for one EX operand; the younger MEM result wins over WB
   function automatic logic [1:0] fwd_sel(
      input logic       we_m,
      input logic [4:0] wa_m,
      input logic       we_w,
      input logic [4:0] wa_w,
      input logic [4:0] src
   );
      if (we_m && (wa_m != 5'd0) && (wa_m == src))
         return FWD_MEM;
      else if (we_w && (wa_w != 5'd0) && (wa_w == src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hilo_mult_seq.sv
// Multi-cycle multu sequencer: start/busy/done/abort and the latency counter.
module hilo_mult_seq
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic multu_en_d,
   input  logic redir,
   input  logic load_use,
   output logic mult_start,
   output logic mult_busy,
   output logic mult_done,
   output logic mult_abort
);

   localparam int unsigned CW = $clog2(MULT_CYCLES);
   localparam logic [CW-1:0] CNT_FIRST = CW'(MULT_CYCLES - 1);

   mult_state_t   state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;

   // State and counter registers; reset silently drops any in-flight multiply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MS_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state, counter and pulse generation
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      mult_start = 1'b0;
      mult_busy  = 1'b0;
      mult_done  = 1'b0;
      mult_abort = 1'b0;
      case (state)
         MS_IDLE: begin
            if (multu_en_d && !redir && !load_use) begin
               mult_start = 1'b1;
               state_nx   = MS_BUSY;
               cnt_nx     = CNT_FIRST;
            end
         end
         MS_BUSY: begin
            mult_busy = 1'b1;
            // Only in the first busy cycle is the multu still in EX, i.e. younger
            // than a transfer resolving in MEM; later redirects are younger than it.
            if ((cnt == CNT_FIRST) && redir) begin
               mult_abort = 1'b1;
               state_nx   = MS_IDLE;
               cnt_nx     = '0;
            end else if (cnt == '0) begin
               mult_done = 1'b1;
               state_nx  = MS_IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = MS_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, stalls, flushes, multu sequencing.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] rs_e,
   input  logic [4:0] rt_e,
   input  logic [4:0] rf_wa_e,
   input  logic [4:0] rf_wa_m,
   input  logic [4:0] rf_wa_w,
   input  logic       we_reg_e,
   input  logic       we_reg_m,
   input  logic       we_reg_w,
   input  logic       dm2reg_e,
   input  logic       multu_en_d,
   input  logic       hilo_rd_d,
   input  logic       branch_m,
   input  logic       zero_m,
   input  logic       jump_m,
   input  logic       jr_sel_m,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic [1:0] fwd_a_e,
   output logic [1:0] fwd_b_e,
   output logic       mult_start,
   output logic       mult_busy,
   output logic       mult_done,
   output logic       mult_abort
);

   logic redir;
   logic load_use;
   logic hilo_haz;

   // Hazard conditions
   always_comb begin
      redir    = (branch_m & zero_m) | jump_m | jr_sel_m;
      load_use = dm2reg_e & we_reg_e & (rf_wa_e != 5'd0) &
                 ((rf_wa_e == rs_d) | (rf_wa_e == rt_d));
      hilo_haz = mult_busy & (multu_en_d | hilo_rd_d);
   end

   // Stall/flush resolution; a redirect overrides every stall
   always_comb begin
      flush_d = redir;
      flush_m = redir;
      flush_e = redir | load_use | hilo_haz;
      stall_f = ~redir & (load_use | hilo_haz);
      stall_d = ~redir & (load_use | hilo_haz);
   end

   // EX operand forwarding
   always_comb begin
      fwd_a_e = fwd_sel(we_reg_m, rf_wa_m, we_reg_w, rf_wa_w, rs_e);
      fwd_b_e = fwd_sel(we_reg_m, rf_wa_m, we_reg_w, rf_wa_w, rt_e);
   end

   hilo_mult_seq #(
      .MULT_CYCLES (MULT_CYCLES)
   ) u_mult_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .multu_en_d (multu_en_d),
      .redir      (redir),
      .load_use   (load_use),
      .mult_start (mult_start),
      .mult_busy  (mult_busy),
      .mult_done  (mult_done),
      .mult_abort (mult_abort)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MULT_CYCLES = 4).
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, rf_wa_e, rf_wa_m, rf_wa_w;
   logic       we_reg_e, we_reg_m, we_reg_w, dm2reg_e;
   logic       multu_en_d, hilo_rd_d, branch_m, zero_m, jump_m, jr_sel_m;
   logic       stall_f, stall_d, flush_d, flush_e, flush_m;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic       mult_start, mult_busy, mult_done, mult_abort;

   int total = 0;
   int bad   = 0;

   // {stall_f, stall_d, flush_d, flush_e, flush_m}
   logic [4:0] ctl;
   // {mult_start, mult_busy, mult_done, mult_abort}
   logic [3:0] mul;
   assign ctl = {stall_f, stall_d, flush_d, flush_e, flush_m};
   assign mul = {mult_start, mult_busy, mult_done, mult_abort};

   pipeline_hazard_ctrl #(.MULT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
      .rf_wa_e(rf_wa_e), .rf_wa_m(rf_wa_m), .rf_wa_w(rf_wa_w),
      .we_reg_e(we_reg_e), .we_reg_m(we_reg_m), .we_reg_w(we_reg_w),
      .dm2reg_e(dm2reg_e), .multu_en_d(multu_en_d), .hilo_rd_d(hilo_rd_d),
      .branch_m(branch_m), .zero_m(zero_m), .jump_m(jump_m), .jr_sel_m(jr_sel_m),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .flush_m(flush_m), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
      .mult_start(mult_start), .mult_busy(mult_busy), .mult_done(mult_done),
      .mult_abort(mult_abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
      rf_wa_e = '0; rf_wa_m = '0; rf_wa_w = '0;
      we_reg_e = 0; we_reg_m = 0; we_reg_w = 0; dm2reg_e = 0;
      multu_en_d = 0; hilo_rd_d = 0;
      branch_m = 0; zero_m = 0; jump_m = 0; jr_sel_m = 0;
   endtask

   // Move to just after the next rising edge; inputs are then driven for that cycle
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      #12;
      total++;
      if ({ctl, mul, fwd_a_e, fwd_b_e} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {ctl, mul, fwd_a_e, fwd_b_e});
      end
      next_cycle();
      rst_n = 1;
      #1;
      total++;
      if ({ctl, mul} !== 9'd0) begin
         bad++;
         $display("FAIL reset_release: got %b want 0", {ctl, mul});
      end
   endtask

   task automatic test_forwarding();
      next_cycle();
      clear_inputs();
      we_reg_m = 1; we_reg_w = 1; rf_wa_m = 5; rf_wa_w = 5; rs_e = 5; rt_e = 9;
      #1;
      total++;
      if ({fwd_a_e, fwd_b_e} !== 4'b10_00) begin
         bad++;
         $display("FAIL fwd_mem_priority: got %b want 1000", {fwd_a_e, fwd_b_e});
      end
      rf_wa_m = 0; rf_wa_w = 0; rs_e = 0; rt_e = 0;
      #1;
      total++;
      if ({fwd_a_e, fwd_b_e} !== 4'b00_00) begin
         bad++;
         $display("FAIL fwd_r0: got %b want 0000", {fwd_a_e, fwd_b_e});
      end
      rf_wa_m = 7; rf_wa_w = 9; rs_e = 7; rt_e = 9;
      #1;
      total++;
      if ({fwd_a_e, fwd_b_e} !== 4'b10_01) begin
         bad++;
         $display("FAIL fwd_mem_wb_split: got %b want 1001", {fwd_a_e, fwd_b_e});
      end
      we_reg_m = 0; rf_wa_m = 12; rf_wa_w = 12; rs_e = 3; rt_e = 12;
      #1;
      total++;
      if ({fwd_a_e, fwd_b_e} !== 4'b00_01) begin
         bad++;
         $display("FAIL fwd_wb_when_mem_off: got %b want 0001", {fwd_a_e, fwd_b_e});
      end
      we_reg_w = 0;
      #1;
      total++;
      if ({fwd_a_e, fwd_b_e} !== 4'b00_00) begin
         bad++;
         $display("FAIL fwd_no_write: got %b want 0000", {fwd_a_e, fwd_b_e});
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      next_cycle();
      clear_inputs();
      dm2reg_e = 1; we_reg_e = 1; rf_wa_e = 8; rt_d = 8; multu_en_d = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b11010, 4'b0000}) begin
         bad++;
         $display("FAIL load_use_stall: got %b want 110100000", {ctl, mul});
      end
      // Bubble now in EX, the multu is still in ID and may start
      next_cycle();
      dm2reg_e = 0; we_reg_e = 0; rf_wa_e = 0;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00000, 4'b1000}) begin
         bad++;
         $display("FAIL load_use_release: got %b want 000001000", {ctl, mul});
      end
      next_cycle();
      clear_inputs();
      repeat (4) next_cycle();
      #1;
      total++;
      if (mul !== 4'b0000) begin
         bad++;
         $display("FAIL load_use_drain: got %b want 0000", mul);
      end
      // Match on rs_d, and the r0 / non-load exemptions
      dm2reg_e = 1; we_reg_e = 1; rf_wa_e = 14; rs_d = 14;
      #1;
      total++;
      if (ctl !== 5'b11010) begin
         bad++;
         $display("FAIL load_use_rs: got %b want 11010", ctl);
      end
      rf_wa_e = 0; rs_d = 0;
      #1;
      total++;
      if (ctl !== 5'b00000) begin
         bad++;
         $display("FAIL load_use_r0: got %b want 00000", ctl);
      end
      rf_wa_e = 14; rs_d = 14; dm2reg_e = 0;
      #1;
      total++;
      if (ctl !== 5'b00000) begin
         bad++;
         $display("FAIL load_use_not_load: got %b want 00000", ctl);
      end
      clear_inputs();
   endtask

   task automatic test_mult_seq();
      next_cycle();
      clear_inputs();
      multu_en_d = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00000, 4'b1000}) begin
         bad++;
         $display("FAIL mult_c0: got %b want 000001000", {ctl, mul});
      end
      next_cycle();
      multu_en_d = 0;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00000, 4'b0100}) begin
         bad++;
         $display("FAIL mult_c1: got %b want 000000100", {ctl, mul});
      end
      for (int c = 2; c <= 3; c++) begin
         next_cycle();
         hilo_rd_d = 1;
         #1;
         total++;
         if ({ctl, mul} !== {5'b11010, 4'b0100}) begin
            bad++;
            $display("FAIL mult_mfhi_c%0d: got %b want 110100100", c, {ctl, mul});
         end
      end
      next_cycle();
      #1;
      total++;
      if ({ctl, mul} !== {5'b11010, 4'b0110}) begin
         bad++;
         $display("FAIL mult_c4_done: got %b want 110100110", {ctl, mul});
      end
      next_cycle();
      #1;
      total++;
      if ({ctl, mul} !== {5'b00000, 4'b0000}) begin
         bad++;
         $display("FAIL mult_c5_release: got %b want 000000000", {ctl, mul});
      end
      clear_inputs();
   endtask

   task automatic test_abort();
      next_cycle();
      clear_inputs();
      multu_en_d = 1;
      next_cycle();
      multu_en_d = 0; jump_m = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00111, 4'b0101}) begin
         bad++;
         $display("FAIL abort_c1: got %b want 001110101", {ctl, mul});
      end
      next_cycle();
      jump_m = 0;
      #1;
      total++;
      if (mul !== 4'b0000) begin
         bad++;
         $display("FAIL abort_c2_idle: got %b want 0000", mul);
      end
      for (int c = 3; c <= 5; c++) begin
         next_cycle();
         #1;
         total++;
         if (mult_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done_c%0d: got %b want 0", c, mult_done);
         end
      end
      clear_inputs();
   endtask

   task automatic test_no_abort();
      next_cycle();
      clear_inputs();
      multu_en_d = 1;
      next_cycle();
      multu_en_d = 0;
      next_cycle();
      branch_m = 1; zero_m = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00111, 4'b0100}) begin
         bad++;
         $display("FAIL no_abort_c2: got %b want 001110100", {ctl, mul});
      end
      next_cycle();
      branch_m = 0; zero_m = 0;
      next_cycle();
      #1;
      total++;
      if (mul !== 4'b0110) begin
         bad++;
         $display("FAIL no_abort_c4_done: got %b want 0110", mul);
      end
      next_cycle();
      #1;
      total++;
      if (mul !== 4'b0000) begin
         bad++;
         $display("FAIL no_abort_c5_idle: got %b want 0000", mul);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      next_cycle();
      clear_inputs();
      multu_en_d = 1;
      next_cycle();
      multu_en_d = 0;
      repeat (3) next_cycle();
      multu_en_d = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b11010, 4'b0110}) begin
         bad++;
         $display("FAIL b2b_done_stall: got %b want 110100110", {ctl, mul});
      end
      next_cycle();
      #1;
      total++;
      if ({ctl, mul} !== {5'b00000, 4'b1000}) begin
         bad++;
         $display("FAIL b2b_second_start: got %b want 000001000", {ctl, mul});
      end
      next_cycle();
      multu_en_d = 0;
      repeat (3) next_cycle();
      #1;
      total++;
      if (mul !== 4'b0110) begin
         bad++;
         $display("FAIL b2b_second_done: got %b want 0110", mul);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_mult();
      next_cycle();
      clear_inputs();
      multu_en_d = 1;
      next_cycle();
      multu_en_d = 0;
      next_cycle();
      rst_n = 0;
      #1;
      total++;
      if (mul !== 4'b0000) begin
         bad++;
         $display("FAIL reset_mid_mult: got %b want 0000", mul);
      end
      next_cycle();
      rst_n = 1; multu_en_d = 1;
      #1;
      total++;
      if (mul !== 4'b1000) begin
         bad++;
         $display("FAIL reset_restart: got %b want 1000", mul);
      end
      next_cycle();
      multu_en_d = 0;
      #1;
      total++;
      if (mul !== 4'b0100) begin
         bad++;
         $display("FAIL reset_restart_busy: got %b want 0100", mul);
      end
      repeat (3) next_cycle();
      #1;
      total++;
      if (mul !== 4'b0110) begin
         bad++;
         $display("FAIL reset_restart_done: got %b want 0110", mul);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_redir_load_use();
      next_cycle();
      clear_inputs();
      dm2reg_e = 1; we_reg_e = 1; rf_wa_e = 8; rt_d = 8; jump_m = 1; multu_en_d = 1;
      #1;
      total++;
      if ({ctl, mul} !== {5'b00111, 4'b0000}) begin
         bad++;
         $display("FAIL redir_over_load_use: got %b want 001110000", {ctl, mul});
      end
      jump_m = 0; jr_sel_m = 1;
      #1;
      total++;
      if (ctl !== 5'b00111) begin
         bad++;
         $display("FAIL redir_jr: got %b want 00111", ctl);
      end
      jr_sel_m = 0; branch_m = 1; zero_m = 0;
      #1;
      total++;
      if (ctl !== 5'b11010) begin
         bad++;
         $display("FAIL branch_not_taken: got %b want 11010", ctl);
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_mult_seq();
      test_abort();
      test_no_abort();
      test_back_to_back();
      test_reset_mid_mult();
      test_redir_load_use();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
